booth_mul_arbiter: RTL and testbench

//  Shares one sequential signed Booth multiplier (start/done wrapped) between NUM_REQ requesters.
//  - Round-robin arbitration, per-requester valid/ready request channel, single response channel tagged with requester id.
//  - Sequences the multiplier: latches operands, pulses start, waits for done, holds the product until the consumer takes it.

---
 rtl/booth_mul_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Shares one external sequential signed Booth multiplier (start/done handshake)
// between NUM_REQ requesters. Requesters are picked round-robin. Each operation
// runs IDLE -> ISSUE -> WAIT -> RESP, and a single response channel returns the
// product together with the id of the requester that asked for it.
// Optional feature: define BOOTH_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles. An aborted operation returns rsp_product=0 with rsp_err=1.
module booth_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_m,
    input  logic [NUM_REQ*WIDTH-1:0]   req_q,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [2*WIDTH-1:0]         rsp_product,
    output logic                       rsp_err,
    output logic                       mul_start,
    output logic [WIDTH-1:0]           mul_m,
    output logic [WIDTH-1:0]           mul_q,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         mul_product
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Round-robin pointer holds the last granted requester.
    logic [IDW-1:0]       r_ptr;
    logic [WIDTH-1:0]     r_mul_m;
    logic [WIDTH-1:0]     r_mul_q;
    logic [IDW-1:0]       r_rsp_id;
    logic [2*WIDTH-1:0]   r_rsp_product;

    // Candidate k is the requester k+1 places after the pointer (wrapping).
    logic [IDW-1:0]       w_cand_idx   [NUM_REQ];
    logic [NUM_REQ-1:0]   w_cand_valid;
    logic [WIDTH-1:0]     w_m_arr      [NUM_REQ];
    logic [WIDTH-1:0]     w_q_arr      [NUM_REQ];
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_found;
    logic [IDW-1:0]       w_gidx;
    logic                 w_take;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDW:0] w_sum;
            assign w_sum             = {1'b0, r_ptr} + (IDW+1)'(gi + 1);
            assign w_cand_idx[gi]    = (w_sum >= (IDW+1)'(NUM_REQ))
                                       ? IDW'(w_sum - (IDW+1)'(NUM_REQ))
                                       : IDW'(w_sum);
            assign w_cand_valid[gi]  = req_valid[w_cand_idx[gi]];
            assign w_m_arr[gi]       = req_m[gi*WIDTH +: WIDTH];
            assign w_q_arr[gi]       = req_q[gi*WIDTH +: WIDTH];
            assign w_grant[gi]       = w_found && (w_gidx == IDW'(gi));
        end
    endgenerate

    // Pick the nearest valid candidate after the pointer. The loop scans
    // downward so that the lowest candidate slot wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_valid[k]) begin
                w_found = 1'b1;
                w_gidx  = w_cand_idx[k];
            end
        end
    end

    assign w_take = w_found && (r_state == S_IDLE);

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wait_cnt;
    logic          r_rsp_err;
    logic          w_expire;

    // The counter is zero on WAIT entry and counts the WAIT cycles that have elapsed.
    assign w_expire = (r_wait_cnt == CW'(TIMEOUT - 1));

    // Count cycles spent in WAIT and clear the counter in every other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the operation sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    w_state_next = S_RESP;
                end
`ifdef BOOTH_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_next = S_RESP;
                end
`endif
            end
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state. A grant is only offered in IDLE.
    always_comb begin
        req_ready = '0;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE:  req_ready = w_grant;
            S_ISSUE: mul_start = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Latch operands and id on grant, and capture the result at the end of WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= IDW'(NUM_REQ - 1);
            r_mul_m       <= '0;
            r_mul_q       <= '0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            r_rsp_err     <= 1'b0;
`endif
        end else begin
            if (w_take) begin
                r_mul_m  <= w_m_arr[w_gidx];
                r_mul_q  <= w_q_arr[w_gidx];
                r_rsp_id <= w_gidx;
                r_ptr    <= w_gidx;
            end
            if (r_state == S_WAIT) begin
                if (mul_done) begin
                    r_rsp_product <= mul_product;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    r_rsp_err     <= 1'b0;
                end else if (w_expire) begin
                    r_rsp_product <= '0;
                    r_rsp_err     <= 1'b1;
`endif
                end
            end
        end
    end

    assign mul_m       = r_mul_m;
    assign mul_q       = r_mul_q;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter
// Directed and randomized bench for booth_mul_arbiter (NUM_REQ=4, WIDTH=4).
// The multiplier model raises done 4 cycles after start. The expected products
// come from plain integer multiplication, and the expected grants come from a
// scan for the first valid requester after the last one served.
module tb_booth_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_m;
    logic [15:0] req_q;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_product;
    logic        rsp_err;
    logic        mul_start;
    logic [3:0]  mul_m;
    logic [3:0]  mul_q;
    logic        mul_done;
    logic [7:0]  mul_product;

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_ptr = 3;

    booth_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_m       (req_m),
        .req_q       (req_q),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .mul_start   (mul_start),
        .mul_m       (mul_m),
        .mul_q       (mul_q),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    always #5 clk = ~clk;

    // Multiplier model: captures operands on start and raises done 4 cycles later.
    int                 mdl_cnt = 0;
    logic signed [7:0]  mdl_m8  = '0;
    logic signed [7:0]  mdl_q8  = '0;
    logic               mdl_mute = 1'b0;
    int                 n_starts = 0;

    always @(posedge clk) begin
        if (mul_start) begin
            mdl_cnt  <= 4;
            mdl_m8   <= {{4{mul_m[3]}}, mul_m};
            mdl_q8   <= {{4{mul_q[3]}}, mul_q};
            n_starts <= n_starts + 1;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign mul_done    = (mdl_cnt == 1) && !mdl_mute;
    assign mul_product = mdl_m8 * mdl_q8;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
        int a;
        int b;
        int p;
        a = $signed(m);
        b = $signed(q);
        p = a * b;
        return p[7:0];
    endfunction

    function automatic int ref_grant(input int ptr, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"},   32'(req_ready),   32'd0);
        check({tag, "_start"},   32'(mul_start),   32'd0);
        check({tag, "_mul_m"},   32'(mul_m),       32'd0);
        check({tag, "_mul_q"},   32'(mul_q),       32'd0);
        check({tag, "_rvalid"},  32'(rsp_valid),   32'd0);
        check({tag, "_rid"},     32'(rsp_id),      32'd0);
        check({tag, "_rprod"},   32'(rsp_product), 32'd0);
        check({tag, "_rerr"},    32'(rsp_err),     32'd0);
    endtask

    // One full operation: grant, issue, wait, optional held response, handshake.
    task automatic serve(input int hold, input logic [3:0] next_valid);
        int         g;
        int         st0;
        logic [3:0] em;
        logic [3:0] eq;
        logic [7:0] ep;
        logic       seen;
        #1;
        g = ref_grant(ref_ptr, req_valid);
        if (g < 0) g = 0;
        check("grant", 32'(req_ready), 32'(1 << g));
        em  = req_m[g*4 +: 4];
        eq  = req_q[g*4 +: 4];
        ep  = ref_prod(em, eq);
        st0 = n_starts;
        tick();
        req_valid = next_valid;
        ref_ptr   = g;
        check("issue_start", 32'(mul_start), 32'd1);
        check("issue_m",     32'(mul_m),     32'(em));
        check("issue_q",     32'(mul_q),     32'(eq));
        check("issue_ready", 32'(req_ready), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                check("wait_ready", 32'(req_ready), 32'd0);
                check("wait_start", 32'(mul_start), 32'd0);
                check("wait_m",     32'(mul_m),     32'(em));
            end
        end
        check("rsp_seen",   32'(seen),        32'd1);
        check("rsp_id",     32'(rsp_id),      32'(g));
        check("rsp_prod",   32'(rsp_product), 32'(ep));
        check("rsp_err",    32'(rsp_err),     32'd0);
        check("start_once", 32'(n_starts),    32'(st0 + 1));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(rsp_valid),   32'd1);
            check("hold_id",    32'(rsp_id),      32'(g));
            check("hold_prod",  32'(rsp_product), 32'(ep));
            check("hold_ready", 32'(req_ready),   32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        $display("op: req=%0d m=%h q=%h product=%h expected=%h hold=%0d", g, em, eq, rsp_product, ep, hold);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check_idle_zero("reset");
        reset = 1'b0;
        tick();

        // Single requester: 3 * -2 = 0xFA.
        req_m[3:0] = 4'd3;
        req_q[3:0] = 4'hE;
        req_valid  = 4'b0001;
        serve(0, 4'b0000);

        // All requesters valid from reset: order 0,1,2,3,0.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        ref_ptr = 3;
        req_m   = 16'h7531;
        req_q   = 16'hC9A2;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) serve(0, 4'b1111);

        // Corner products: -8*-8 = 0x40 and 7*-8 = 0xC8.
        req_valid   = 4'b0010;
        req_m[7:4]  = 4'h8;
        req_q[7:4]  = 4'h8;
        serve(0, 4'b0000);
        req_valid   = 4'b0010;
        req_m[7:4]  = 4'h7;
        req_q[7:4]  = 4'h8;
        serve(0, 4'b0000);

        // Backpressure: response held for 5 cycles with every requester pending.
        req_valid = 4'b1111;
        serve(5, 4'b1111);

        // Reset pulsed during WAIT aborts silently; a late done must be ignored.
        req_valid = 4'b0100;
        #1;
        check("abort_grant", 32'(req_ready), 32'(1 << ref_grant(ref_ptr, 4'b0100)));
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        ref_ptr = 3;
        check_idle_zero("abort");
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_rsp",   32'(rsp_valid), 32'd0);
            check("abort_no_start", 32'(mul_start), 32'd0);
        end
        req_valid = 4'b1111;
        serve(0, 4'b0000);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 30; i++) begin
            req_m     = 16'($urandom);
            req_q     = 16'($urandom);
            req_valid = 4'($urandom_range(1, 15));
            serve(int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Multiplier never answers: abort after TIMEOUT WAIT cycles.
        begin
            int   g;
            int   cyc;
            logic seen;
            mdl_mute  = 1'b1;
            req_valid = 4'b0001;
            req_m[3:0] = 4'd5;
            req_q[3:0] = 4'd5;
            #1;
            g = ref_grant(ref_ptr, req_valid);
            check("to_grant", 32'(req_ready), 32'(1 << g));
            tick();
            req_valid = 4'b0000;
            ref_ptr   = g;
            check("to_start", 32'(mul_start), 32'd1);
            cyc  = 0;
            seen = 1'b0;
            for (int c = 0; c < 60 && !seen; c++) begin
                tick();
                cyc++;
                if (rsp_valid) seen = 1'b1;
            end
            check("to_seen",    32'(seen),        32'd1);
            check("to_latency", 32'(cyc),         32'(TIMEOUT + 1));
            check("to_err",     32'(rsp_err),     32'd1);
            check("to_prod",    32'(rsp_product), 32'd0);
            check("to_id",      32'(rsp_id),      32'(g));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("to_drop", 32'(rsp_valid), 32'd0);
            $display("op: timeout req=%0d latency=%0d err=%0d", g, cyc, rsp_err);
            mdl_mute = 1'b0;
            tick();
            tick();
            req_valid  = 4'b1000;
            serve(0, 4'b0000);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
